// File: rtl/sar_compare_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encoding and the comparator flag-validity check.
package sar_compare_search_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRIAL  = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // A well-behaved comparator raises exactly one of gt / eq / lt.
    function automatic logic flags_valid(input logic x, input logic y, input logic z);
        return ({x, y, z} == 3'b100) || ({x, y, z} == 3'b010) || ({x, y, z} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_compare_search_settle_timer.sv
// Loadable down-counter that stretches each trial so comparator flags can settle.
module sar_compare_search_settle_timer #(
    parameter int LOAD = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic zero_o
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = 4'(LOAD);
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/sar_compare_search.sv
// Binary-search controller: drives the comparator b operand and recovers the value
// on its a input from the gt/eq/lt verdicts, one bit per trial.
module sar_compare_search
    import sar_compare_search_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_x,
    input  logic             cmp_y,
    input  logic             cmp_z,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             timer_load;
    logic             timer_zero;
    logic [WIDTH-1:0] new_acc;
    logic [WIDTH-1:0] next_bit_mask;

    sar_compare_search_settle_timer #(
        .LOAD (SETTLE_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (timer_load),
        .zero_o (timer_zero)
    );

    assign new_acc       = cmp_x ? guess_q : acc_q;
    assign next_bit_mask = ONE << (bit_q - BW'(1));

    // Flags are only trusted on the last cycle of a trial (timer at zero).
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        bit_d      = bit_q;
        guess_d    = guess_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        found_d    = found_q;
        err_d      = err_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    acc_d      = '0;
                    bit_d      = BW'(WIDTH - 1);
                    guess_d    = MSB;
                    busy_d     = 1'b1;
                    found_d    = 1'b0;
                    err_d      = 1'b0;
                    timer_load = 1'b1;
                    state_d    = ST_TRIAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRIAL: begin
                if (timer_zero) begin
                    if (!flags_valid(cmp_x, cmp_y, cmp_z)) begin
                        err_d    = 1'b1;
                        found_d  = 1'b0;
                        result_d = acc_q;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (cmp_y) begin
                        result_d = guess_q;
                        found_d  = 1'b1;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        acc_d      = new_acc;
                        timer_load = 1'b1;
                        if (bit_q != '0) begin
                            bit_d   = bit_q - BW'(1);
                            guess_d = new_acc | next_bit_mask;
                        end else begin
                            guess_d = new_acc;
                            state_d = ST_VERIFY;
                        end
                    end
                end
            end
            ST_VERIFY: begin
                if (timer_zero) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                    if (!flags_valid(cmp_x, cmp_y, cmp_z)) begin
                        err_d    = 1'b1;
                        found_d  = 1'b0;
                        result_d = acc_q;
                    end else begin
                        found_d  = cmp_y;
                        result_d = guess_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            bit_q    <= '0;
            guess_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign found  = found_q;
    assign err    = err_q;

endmodule
